lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
Load/store unit that initiates every access to the data memory on behalf of the datapath. Accepts byte, halfword and word load/store requests and issues word-aligned reads and writes on the data memory port. Extracts and sign- or zero-extends load data. Performs read-modify-write for sub-word stores. Sits between the execute/memory stage and the data memory, which has a combinational read, a posedge write, and little-endian byte lanes at address..address+3.

Parameters:
AW, 32, request and memory address width in bits
DW, 32, data width in bits (fixed at 4 bytes)

Ports:
clk  input  1  system clock, all state changes on posedge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (IDLE only)
req_write  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_signed  input  1  sign-extend load result (ignored for word and for stores)
req_addr  input  AW  byte address
req_wdata  input  DW  store data, right-justified (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  DW  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or illegal-size request; valid with resp_valid
mem_we  output  1  data memory write enable
mem_addr  output  AW  word-aligned memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data (combinational from mem_addr)

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0, all internal latches 0.
- Reset is asynchronous. Assertion in any state returns to IDLE immediately. mem_we falls in the same cycle, so no partial write commits at the next edge.
- States: IDLE, RD, WR, RESP. req_ready = (state == IDLE).
- IDLE: on a posedge with req_valid=1, latch write, size, signed, addr, wdata.
  - Error if size==3, size==1 with addr[0]=1, or size==2 with addr[1:0]!=0 -> RESP with err=1; no memory access.
  - Load -> RD.
  - Word store -> WR.
  - Byte or half store -> RD.
- RD: mem_addr = {addr[AW-1:2],2'b00}, mem_we=0. Capture mem_rdata at the posedge.
  - Load -> RESP, with resp_rdata = the extracted lane, extended per the signed latch.
  - Store -> WR.
- WR: mem_we=1 for exactly this cycle. mem_addr aligned as above.
  - mem_wdata = wdata for a word store.
  - For a sub-word store, mem_wdata = the captured word with the addressed byte lane (addr[1:0]) or halfword lane (addr[1]) replaced by the low bits of wdata. Other lanes are unchanged.
  - Next state -> RESP.
- RESP: resp_valid=1 for one cycle; no back-pressure. Next state -> IDLE; a new request can be accepted on the following edge.
- Lane mapping: byte k = bits [8k+7:8k]; halfword h = bits [16h+15:16h].
- Latency, counted from the accepting edge to the cycle with resp_valid high:
  - error: 1 cycle
  - load or word store: 2 cycles
  - sub-word store: 3 cycles
- Outside WR: mem_we=0 and mem_wdata=0. mem_addr holds its last aligned value.
- resp_rdata and resp_err are 0 whenever resp_valid=0.
- req_valid while req_ready=0 is ignored and not queued. The requester holds it until acceptance.

Test Plan:
- Memory word at 0x10 = 0x8899AABB; word load at 0x10 -> resp_valid 2 cycles after accept, resp_rdata=0x8899AABB, err=0, mem_we never high.
- Byte load at 0x13: signed -> 0xFFFFFF88, unsigned -> 0x00000088. Half load at 0x12 signed -> 0xFFFF8899. Half load at 0x10 unsigned -> 0x0000AABB.
- Byte store at 0x11 with wdata 0x000000CC -> RD cycle (mem_we=0, mem_addr=0x10), then WR cycle (mem_we=1, mem_wdata=0x8899CCBB). Resp at +3; memory reads back 0x8899CCBB.
- Word store at 0x10 with 0x12345678 -> no RD cycle, single mem_we pulse, resp at +2, readback 0x12345678. Back-to-back requests give req_ready low from the accept edge until IDLE.
- Half load at 0x11, and size=3 at 0x10 -> resp_err=1 at +1, resp_rdata=0, mem_we never asserted.
- Assert reset asynchronously during WR of a half store to 0x12 -> mem_we drops immediately, memory unchanged, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_mem_master_if.sv
// Bundles the request/response handshake and the data memory port of the
// load/store unit. The LSU uses the master view; the datapath/memory side
// uses the slave view.
interface lsu_mem_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store unit: turns byte/half/word load and store requests into
// word-aligned accesses on the data memory port. Loads are extracted and
// extended from the addressed lane; sub-word stores do a read-modify-write
// so the untouched lanes of the memory word are preserved.
module lsu_mem_master #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  lsu_mem_master_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t        state_q, state_d;

  logic          wr_q;
  logic [1:0]    size_q;
  logic          sgn_q;
  logic [1:0]    lane_q;
  logic [DW-1:0] wdata_q;
  logic          err_q;
  logic [DW-1:0] word_q;
  logic [AW-1:0] maddr_q;

  logic          req_err;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic [DW-1:0] load_ext;
  logic [DW-1:0] merged;

  // A request is rejected up front when the size is illegal or the address
  // is not naturally aligned for that size.
  assign req_err = (bus.req_size == 2'd3) ||
                   ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                   ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

  // State register; reset pulls the FSM back to IDLE at once, which also
  // drops mem_we combinationally so a write in flight never commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latches, aligned memory address and the word read in RD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      sgn_q   <= 1'b0;
      lane_q  <= 2'd0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
      maddr_q <= '0;
    end else begin
      if ((state_q == IDLE) && bus.req_valid) begin
        wr_q    <= bus.req_write;
        size_q  <= bus.req_size;
        sgn_q   <= bus.req_signed;
        lane_q  <= bus.req_addr[1:0];
        wdata_q <= bus.req_wdata;
        err_q   <= req_err;
        if (!req_err) begin
          maddr_q <= {bus.req_addr[AW-1:2], 2'b00};
        end
      end
      if (state_q == RD) begin
        word_q <= bus.mem_rdata;
      end
    end
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores.
  always_comb begin
    load_byte = word_q[{lane_q, 3'b000} +: 8];
    load_half = word_q[{lane_q[1], 4'b0000} +: 16];
    load_ext  = word_q;
    merged    = word_q;
    case (size_q)
      SZ_BYTE: begin
        load_ext = {{(DW-8){sgn_q & load_byte[7]}}, load_byte};
        merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_ext = {{(DW-16){sgn_q & load_half[15]}}, load_half};
        merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: begin
        load_ext = word_q;
        merged   = wdata_q;
      end
    endcase
  end

  // Next-state decode and all handshake/memory outputs.
  always_comb begin
    state_d         = state_q;
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_rdata  = '0;
    bus.resp_err    = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_wdata   = '0;
    bus.mem_addr    = maddr_q;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err) begin
            state_d = RESP;
          end else if (!bus.req_write) begin
            state_d = RD;
          end else if (bus.req_size == SZ_WORD) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        state_d = wr_q ? WR : RESP;
      end
      WR: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = merged;
        state_d       = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        if (!err_q && !wr_q) begin
          bus.resp_rdata = load_ext;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: a table of load/store requests with
// hand-computed results run against a small word memory, followed by
// hand-written back-to-back and asynchronous-reset sequences.
module tb_lsu_mem_master;

  logic clk;
  logic reset;
  logic memLoad;

  lsu_mem_master_if #(.AW(32), .DW(32)) bus ();

  lsu_mem_master #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:63];

  int tests;
  int failures;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
    logic [31:0] expWdata;
    logic [31:0] expMem;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  // Free-running clock, posedges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: combinational read, posedge write, preloadable.
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (memLoad) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
      mem[4] <= 32'h8899AABB;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issue one request and watch it until resp_valid (bounded to 10 cycles).
  task automatic applyStimulus(input vec_t v, output int lat,
                               output logic [31:0] rdata, output logic err,
                               output int weCnt, output logic [31:0] wdataSeen,
                               output logic [31:0] firstAddr,
                               output int readyHigh);
    lat = 0; rdata = '0; err = 1'b0; weCnt = 0; wdataSeen = '0;
    firstAddr = '0; readyHigh = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = v.wr;
    bus.req_size   = v.size;
    bus.req_signed = v.sgn;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (n == 1) firstAddr = bus.mem_addr;
      if (bus.mem_we) begin
        weCnt++;
        wdataSeen = bus.mem_wdata;
      end
      if (bus.req_ready) readyHigh++;
      if (bus.resp_valid) begin
        lat   = n;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        break;
      end
    end
  endtask

  // Bound on total run time.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          weCnt;
    logic [31:0] wdataSeen;
    logic [31:0] firstAddr;
    int          readyHigh;
    logic        expWe;
    logic        expReady [1:5];
    logic        expResp  [1:5];

    tests = 0;
    failures = 0;

    //            wr    size  sgn   addr      wdata         expRdata      err   lat  expWdata      expMem
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h00000000, 32'h8899AABB, 1'b0, 2, 32'h00000000, 32'h8899AABB};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h00000000, 32'hFFFFFF88, 1'b0, 2, 32'h00000000, 32'h8899AABB};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h00000000, 32'h00000088, 1'b0, 2, 32'h00000000, 32'h8899AABB};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h00000000, 32'hFFFF8899, 1'b0, 2, 32'h00000000, 32'h8899AABB};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h00000000, 32'h0000AABB, 1'b0, 2, 32'h00000000, 32'h8899AABB};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h10, 32'h00000000, 32'hFFFFFFBB, 1'b0, 2, 32'h00000000, 32'h8899AABB};
    vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h00000000, 32'h000000AA, 1'b0, 2, 32'h00000000, 32'h8899AABB};
    vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h00000000, 32'h00000000, 1'b1, 1, 32'h00000000, 32'h8899AABB};
    vecs[8]  = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h00000000, 32'h00000000, 1'b1, 1, 32'h00000000, 32'h8899AABB};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h12, 32'h00000000, 32'h00000000, 1'b1, 1, 32'h00000000, 32'h8899AABB};
    vecs[10] = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h000000CC, 32'h00000000, 1'b0, 3, 32'h8899CCBB, 32'h8899CCBB};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h00000000, 32'h8899CCBB, 1'b0, 2, 32'h00000000, 32'h8899CCBB};
    vecs[12] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'hDEAD1234, 32'h00000000, 1'b0, 3, 32'h1234CCBB, 32'h1234CCBB};
    vecs[13] = '{1'b1, 2'd0, 1'b1, 32'h13, 32'hFFFFFF77, 32'h00000000, 1'b0, 3, 32'h7734CCBB, 32'h7734CCBB};
    vecs[14] = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 32'h00000000, 1'b0, 2, 32'h12345678, 32'h12345678};
    vecs[15] = '{1'b1, 2'd1, 1'b0, 32'h14, 32'h0000BEEF, 32'h00000000, 1'b0, 3, 32'h0000BEEF, 32'h0000BEEF};
    vecs[16] = '{1'b0, 2'd1, 1'b1, 32'h14, 32'h00000000, 32'hFFFFBEEF, 1'b0, 2, 32'h00000000, 32'h0000BEEF};
    vecs[17] = '{1'b1, 2'd1, 1'b0, 32'h13, 32'h0000FFFF, 32'h00000000, 1'b1, 1, 32'h00000000, 32'h12345678};
    vecs[18] = '{1'b0, 2'd0, 1'b1, 32'h12, 32'h00000000, 32'h00000034, 1'b0, 2, 32'h00000000, 32'h12345678};

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    memLoad = 1'b1;
    reset   = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req_ready",  {31'b0, bus.req_ready},  32'h1);
    checkOutput("reset resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    checkOutput("reset resp_rdata", bus.resp_rdata,          32'h0);
    checkOutput("reset resp_err",   {31'b0, bus.resp_err},   32'h0);
    checkOutput("reset mem_we",     {31'b0, bus.mem_we},     32'h0);
    checkOutput("reset mem_addr",   bus.mem_addr,            32'h0);
    checkOutput("reset mem_wdata",  bus.mem_wdata,           32'h0);
    memLoad = 1'b0;
    reset   = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], lat, rdata, err, weCnt, wdataSeen, firstAddr, readyHigh);
      expWe = vecs[i].wr && !vecs[i].expErr;
      checkOutput($sformatf("v%0d latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("v%0d resp_rdata", i), rdata, vecs[i].expRdata);
      checkOutput($sformatf("v%0d resp_err", i), {31'b0, err}, {31'b0, vecs[i].expErr});
      checkOutput($sformatf("v%0d mem_we pulses", i), weCnt, expWe ? 1 : 0);
      checkOutput($sformatf("v%0d req_ready while busy", i), readyHigh, 0);
      checkOutput($sformatf("v%0d memory word", i), mem[vecs[i].addr[7:2]], vecs[i].expMem);
      if (expWe)
        checkOutput($sformatf("v%0d mem_wdata", i), wdataSeen, vecs[i].expWdata);
      if (!vecs[i].expErr)
        checkOutput($sformatf("v%0d mem_addr", i), firstAddr, {vecs[i].addr[31:2], 2'b00});
    end

    // Held request: accepted, completes, then accepted again after IDLE.
    expReady = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    expResp  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd2;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h10;
    @(posedge clk);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b req_ready c%0d", n), {31'b0, bus.req_ready}, {31'b0, expReady[n]});
      checkOutput($sformatf("b2b resp_valid c%0d", n), {31'b0, bus.resp_valid}, {31'b0, expResp[n]});
      if (n == 2 || n == 5)
        checkOutput($sformatf("b2b resp_rdata c%0d", n), bus.resp_rdata, 32'h12345678);
      else
        checkOutput($sformatf("b2b resp_rdata idle c%0d", n), bus.resp_rdata, 32'h0);
    end
    bus.req_valid = 1'b0;

    // Asynchronous reset in the WR cycle of a half store to 0x12.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'd1;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h12;
    bus.req_wdata  = 32'h0000AAAA;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("rst RD mem_we",   {31'b0, bus.mem_we}, 32'h0);
    checkOutput("rst RD mem_addr", bus.mem_addr,        32'h10);
    @(negedge clk);
    checkOutput("rst WR mem_we",    {31'b0, bus.mem_we}, 32'h1);
    checkOutput("rst WR mem_wdata", bus.mem_wdata,       32'hAAAA5678);
    #1 reset = 1'b1;
    #1;
    checkOutput("rst mem_we drop",   {31'b0, bus.mem_we},    32'h0);
    checkOutput("rst req_ready",     {31'b0, bus.req_ready}, 32'h1);
    checkOutput("rst mem_wdata",     bus.mem_wdata,          32'h0);
    @(negedge clk);
    checkOutput("rst memory intact", mem[4],                  32'h12345678);
    checkOutput("rst no resp",       {31'b0, bus.resp_valid}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post-rst req_ready",  {31'b0, bus.req_ready},  32'h1);
    checkOutput("post-rst resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    checkOutput("post-rst mem_addr",   bus.mem_addr,            32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
